// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register feeding the regfile write port, HI/LO and LL-bit.
// Handles stall-driven bubbles/holds and flush.
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_llbit_we,
    input  logic              mem_llbit_value,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_llbit_we,
    output logic              wb_llbit_value
);
    logic w_bubble;
    logic w_load;
    assign w_bubble = flush || (stall[4] && !stall[5]);
    assign w_load   = !stall[4];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wd          <= '0;
            wb_wreg        <= 1'b0;
            wb_wdata       <= '0;
            wb_whilo       <= 1'b0;
            wb_hi          <= '0;
            wb_lo          <= '0;
            wb_llbit_we    <= 1'b0;
            wb_llbit_value <= 1'b0;
        end else if (w_bubble) begin
            wb_wd          <= '0;
            wb_wreg        <= 1'b0;
            wb_wdata       <= '0;
            wb_whilo       <= 1'b0;
            wb_hi          <= '0;
            wb_lo          <= '0;
            wb_llbit_we    <= 1'b0;
            wb_llbit_value <= 1'b0;
        end else if (w_load) begin
            // Writes to $0 are suppressed so forwarding never matches it
            wb_wd          <= mem_wd;
            wb_wreg        <= mem_wreg && (mem_wd != '0);
            wb_wdata       <= mem_wdata;
            wb_whilo       <= mem_whilo;
            wb_hi          <= mem_hi;
            wb_lo          <= mem_lo;
            wb_llbit_we    <= mem_llbit_we;
            wb_llbit_value <= mem_llbit_value;
        end
    end
endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: vector table, reset/hold sequences and randomized run against a reference model.
module tb_mem_wb;
    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
    } out_t;
    typedef struct packed {
        logic       flush;
        logic [5:0] stall;
        out_t       m;
    } in_t;
    typedef struct {
        string nm;
        in_t   i;
        out_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  drv = '0;
    out_t act;
    out_t cur = '0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [4:0]  o_wd;
    logic        o_wreg, o_whilo, o_llwe, o_llval;
    logic [31:0] o_wdata, o_hi, o_lo;
    vec_t tbl[13];

    always #5 clk = ~clk;

    mem_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(drv.stall), .flush(drv.flush),
        .mem_wd(drv.m.wd), .mem_wreg(drv.m.wreg), .mem_wdata(drv.m.wdata),
        .mem_whilo(drv.m.whilo), .mem_hi(drv.m.hi), .mem_lo(drv.m.lo),
        .mem_llbit_we(drv.m.llwe), .mem_llbit_value(drv.m.llval),
        .wb_wd(o_wd), .wb_wreg(o_wreg), .wb_wdata(o_wdata),
        .wb_whilo(o_whilo), .wb_hi(o_hi), .wb_lo(o_lo),
        .wb_llbit_we(o_llwe), .wb_llbit_value(o_llval)
    );

    assign act = {o_wd, o_wreg, o_wdata, o_whilo, o_hi, o_lo, o_llwe, o_llval};

    function automatic out_t f(logic [4:0] wd, logic wreg, logic [31:0] wdata, logic whilo,
                               logic [31:0] hi, logic [31:0] lo, logic llwe, logic llval);
        out_t r;
        r = {wd, wreg, wdata, whilo, hi, lo, llwe, llval};
        return r;
    endfunction

    // Next WB contents from the priority rules: flush/bubble, load (with $0 masking), hold
    function automatic out_t model(out_t c, in_t x);
        out_t r;
        if (x.flush || (x.stall[4] && !x.stall[5])) return '0;
        if (x.stall[4]) return c;
        r = x.m;
        r.wreg = x.m.wreg && (x.m.wd != 5'd0);
        return r;
    endfunction

    task automatic chk(string nm, out_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, act, e);
        end
        cur = e;
    endtask

    task automatic step(string nm, in_t x, out_t e);
        drv = x;
        @(posedge clk);
        #1;
        chk(nm, e);
    endtask

    initial begin
        out_t a, b, e;
        in_t  x;
        tbl[0]  = '{"pass",     {1'b0, 6'b000000, f(5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0)}, f(5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0)};
        tbl[1]  = '{"zero_reg", {1'b0, 6'b000000, f(5'd0, 1, 32'h12345678, 0, 0, 0, 0, 0)}, f(5'd0, 0, 32'h12345678, 0, 0, 0, 0, 0)};
        tbl[2]  = '{"load7",    {1'b0, 6'b000000, f(5'd7, 1, 32'h1, 0, 0, 0, 0, 0)},        f(5'd7, 1, 32'h1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{"bubble1",  {1'b0, 6'b010000, f(5'd9, 1, 32'h55, 1, 1, 1, 1, 1)},       '0};
        tbl[4]  = '{"bubble2",  {1'b0, 6'b010000, f(5'd9, 1, 32'h55, 1, 1, 1, 1, 1)},       '0};
        tbl[5]  = '{"hilo",     {1'b0, 6'b000000, f(5'd2, 0, 32'h0, 1, 32'hA, 32'hB, 0, 0)}, f(5'd2, 0, 32'h0, 1, 32'hA, 32'hB, 0, 0)};
        tbl[6]  = '{"hold1",    {1'b0, 6'b110000, f(5'd4, 1, 32'hFF, 0, 32'h1, 32'h2, 1, 1)}, f(5'd2, 0, 32'h0, 1, 32'hA, 32'hB, 0, 0)};
        tbl[7]  = '{"hold2",    {1'b0, 6'b110000, f(5'd4, 1, 32'hFF, 0, 32'h1, 32'h2, 1, 1)}, f(5'd2, 0, 32'h0, 1, 32'hA, 32'hB, 0, 0)};
        tbl[8]  = '{"hold3",    {1'b0, 6'b110000, f(5'd4, 1, 32'hFF, 0, 32'h1, 32'h2, 1, 1)}, f(5'd2, 0, 32'h0, 1, 32'hA, 32'hB, 0, 0)};
        tbl[9]  = '{"release",  {1'b0, 6'b000000, f(5'd4, 1, 32'hFF, 0, 32'h1, 32'h2, 1, 1)}, f(5'd4, 1, 32'hFF, 0, 32'h1, 32'h2, 1, 1)};
        tbl[10] = '{"flush_hd", {1'b1, 6'b110000, f(5'd6, 1, 32'h66, 1, 32'h3, 32'h4, 1, 1)}, '0};
        tbl[11] = '{"ign_bits", {1'b0, 6'b101111, f(5'd31, 1, 32'hCAFE, 1, 32'h5, 32'h6, 1, 0)}, f(5'd31, 1, 32'hCAFE, 1, 32'h5, 32'h6, 1, 0)};
        tbl[12] = '{"flush_s0", {1'b1, 6'b000000, f(5'd8, 1, 32'h88, 1, 32'h7, 32'h8, 1, 1)}, '0};

        @(posedge clk);
        #1;
        chk("reset", '0);
        rst = 1'b1;
        foreach (tbl[k]) step(tbl[k].nm, tbl[k].i, tbl[k].e);

        // Asynchronous reset between edges with non-zero inputs
        a = f(5'd10, 1, 32'h77, 1, 32'h11, 32'h22, 1, 1);
        step("pre_rst", {1'b0, 6'b0, a}, a);
        b = f(5'd12, 1, 32'h99, 1, 32'h33, 32'h44, 1, 0);
        drv = {1'b0, 6'b0, b};
        #2 rst = 1'b0;
        #1 chk("async_rst", '0);
        @(posedge clk);
        #1;
        chk("rst_held", '0);
        rst = 1'b1;
        step("rst_release", {1'b0, 6'b0, b}, b);

        // Reset during a hold drops the held contents
        step("pre_hold", {1'b0, 6'b110000, a}, b);
        #2 rst = 1'b0;
        #1 chk("rst_in_hold", '0);
        @(posedge clk);
        #1 rst = 1'b1;
        step("hold_after_rst", {1'b0, 6'b110000, a}, '0);

        for (int k = 0; k < 400; k++) begin
            x.flush = ($urandom_range(7) == 0);
            x.stall = 6'($urandom);
            x.m.wd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            x.m.wreg = 1'($urandom);
            x.m.wdata = $urandom;
            x.m.whilo = 1'($urandom);
            x.m.hi = $urandom;
            x.m.lo = $urandom;
            x.m.llwe = 1'($urandom);
            x.m.llval = 1'($urandom);
            e = model(cur, x);
            step("random", x, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
